// File: rtl/weight_bank_pkg.sv
// Shared state encoding and default geometry for the weight bank.
// addr_w() gives the width of an index that must be at least one bit.
package weight_bank_pkg;

   localparam int DEF_M    = 8;
   localparam int DEF_S    = 8;
   localparam int DEF_N    = 32;
   localparam int DEF_FRAC = 16;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_READ = 2'd2
   } state_t;

   function automatic int addr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

endpackage

// File: rtl/weight_load_ptr.sv
// Row/column write pointer for weight loading; column runs fastest and the
// pointer returns to (0,0) after the last word of the bank.
module weight_load_ptr
   import weight_bank_pkg::*;
#(
   parameter  int M  = DEF_M,
   parameter  int S  = DEF_S,
   localparam int AW = addr_w(S),
   localparam int CW = addr_w(M)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          adv,
   output logic [AW-1:0] row,
   output logic [CW-1:0] col,
   output logic          last
);

   logic [AW-1:0] row_q, row_d;
   logic [CW-1:0] col_q, col_d;
   logic          col_wrap;

   assign col_wrap = (32'(col_q) == M - 1);
   assign last     = col_wrap && (32'(row_q) == S - 1);
   assign row      = row_q;
   assign col      = col_q;

   always_comb begin
      row_d = row_q;
      col_d = col_q;
      if (adv) begin
         if (last) begin
            row_d = '0;
            col_d = '0;
         end else if (col_wrap) begin
            row_d = row_q + AW'(1);
            col_d = '0;
         end else begin
            col_d = col_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         row_q <= '0;
         col_q <= '0;
      end else begin
         row_q <= row_d;
         col_q <= col_d;
      end
   end

endmodule

// File: rtl/weight_bank.sv
// S x M bank of fixed-point weights: streamed in word by word, read out a
// row at a time (single row or full sweep) through a valid/ready port.
module weight_bank
   import weight_bank_pkg::*;
#(
   parameter  int M    = DEF_M,
   parameter  int S    = DEF_S,
   parameter  int n    = DEF_N,
   parameter  int FRAC = DEF_FRAC,
   localparam int AW   = addr_w(S)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load_valid,
   output logic          load_ready,
   input  logic [n-1:0]  load_data,
   output logic          load_done,
   input  logic          rd_start,
   input  logic          rd_mode,
   input  logic [AW-1:0] rd_addr,
   output logic          rd_err,
   output logic [M*n-1:0] W,
   output logic          W_valid,
   input  logic          W_ready,
   output logic          W_last,
   output logic          busy
);

   localparam int CW = addr_w(M);
   localparam logic [n-1:0] RST_WORD = {{(n-1){1'b0}}, 1'b1} << FRAC;

   state_t         state_q, state_d;
   logic [n-1:0]   mem_q [S][M];
   logic [n-1:0]   mem_d [S][M];
   logic [M*n-1:0] w_q, w_d;
   logic           w_valid_q, w_valid_d;
   logic           w_last_q, w_last_d;
   logic [AW-1:0]  rd_row_q, rd_row_d;
   logic           rd_err_q, rd_err_d;
   logic           load_done_q, load_done_d;
   logic           rdy_en_q;

   logic [AW-1:0]  ptr_row;
   logic [CW-1:0]  ptr_col;
   logic           ptr_last;
   logic           wr_en;
   logic           rd_go;
   logic           load_row;
   logic [AW-1:0]  sel_row;

   // rdy_en_q keeps load_ready low through reset and up to the first edge after it.
   assign rd_go      = rd_start && (state_q == ST_IDLE) && (rd_mode || (32'(rd_addr) < S));
   assign load_ready = rdy_en_q && (state_q != ST_READ) && !rd_go;
   assign wr_en      = load_valid && load_ready;

   assign W         = w_q;
   assign W_valid   = w_valid_q;
   assign W_last    = w_last_q;
   assign rd_err    = rd_err_q;
   assign load_done = load_done_q;
   assign busy      = (state_q != ST_IDLE);

   weight_load_ptr #(.M(M), .S(S)) u_ptr (
      .clk  (clk),
      .rst  (rst),
      .adv  (wr_en),
      .row  (ptr_row),
      .col  (ptr_col),
      .last (ptr_last)
   );

   always_comb begin
      state_d     = state_q;
      mem_d       = mem_q;
      w_d         = w_q;
      w_valid_d   = w_valid_q;
      w_last_d    = w_last_q;
      rd_row_d    = rd_row_q;
      rd_err_d    = 1'b0;
      load_done_d = 1'b0;
      load_row    = 1'b0;
      sel_row     = rd_row_q;

      if (wr_en) begin
         mem_d[ptr_row][ptr_col] = load_data;
      end

      case (state_q)
         ST_IDLE: begin
            if (rd_go) begin
               sel_row   = rd_mode ? '0 : rd_addr;
               rd_row_d  = sel_row;
               load_row  = 1'b1;
               w_valid_d = 1'b1;
               w_last_d  = !rd_mode || (S == 1);
               state_d   = ST_READ;
            end else begin
               rd_err_d = rd_start;
               if (wr_en) begin
                  load_done_d = ptr_last;
                  state_d     = ptr_last ? ST_IDLE : ST_LOAD;
               end
            end
         end
         ST_LOAD: begin
            rd_err_d = rd_start;
            if (wr_en && ptr_last) begin
               load_done_d = 1'b1;
               state_d     = ST_IDLE;
            end
         end
         ST_READ: begin
            rd_err_d = rd_start;
            if (W_ready) begin
               if (w_last_q) begin
                  w_valid_d = 1'b0;
                  w_last_d  = 1'b0;
                  state_d   = ST_IDLE;
               end else begin
                  sel_row  = rd_row_q + AW'(1);
                  rd_row_d = sel_row;
                  load_row = 1'b1;
                  w_last_d = (32'(rd_row_q) + 1 == S - 1);
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (load_row) begin
         for (int c = 0; c < M; c++) begin
            w_d[c*n +: n] = mem_q[sel_row][c];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         w_q         <= '0;
         w_valid_q   <= 1'b0;
         w_last_q    <= 1'b0;
         rd_row_q    <= '0;
         rd_err_q    <= 1'b0;
         load_done_q <= 1'b0;
         rdy_en_q    <= 1'b0;
         for (int r = 0; r < S; r++) begin
            for (int c = 0; c < M; c++) begin
               mem_q[r][c] <= RST_WORD;
            end
         end
      end else begin
         state_q     <= state_d;
         w_q         <= w_d;
         w_valid_q   <= w_valid_d;
         w_last_q    <= w_last_d;
         rd_row_q    <= rd_row_d;
         rd_err_q    <= rd_err_d;
         load_done_q <= load_done_d;
         rdy_en_q    <= 1'b1;
         mem_q       <= mem_d;
      end
   end

endmodule

// File: tb/tb_weight_bank.sv
// Directed bench for weight_bank: a default build plus an S=10 build used
// for the out-of-range row-address checks.
module tb_weight_bank;

   localparam logic [255:0] RST_ROW = {8{32'h00010000}};

   logic         clk;
   logic         rst;

   logic         load_valid, load_ready, load_done;
   logic [31:0]  load_data;
   logic         rd_start, rd_mode, rd_err;
   logic [2:0]   rd_addr;
   logic [255:0] W;
   logic         W_valid, W_ready, W_last, busy;

   logic         load_valid10, load_ready10, load_done10;
   logic [31:0]  load_data10;
   logic         rd_start10, rd_mode10, rd_err10;
   logic [3:0]   rd_addr10;
   logic [255:0] W10;
   logic         W_valid10, W_ready10, W_last10, busy10;

   int n_checks = 0;
   int n_fail   = 0;

   weight_bank dut (
      .clk(clk), .rst(rst),
      .load_valid(load_valid), .load_ready(load_ready), .load_data(load_data),
      .load_done(load_done), .rd_start(rd_start), .rd_mode(rd_mode),
      .rd_addr(rd_addr), .rd_err(rd_err), .W(W), .W_valid(W_valid),
      .W_ready(W_ready), .W_last(W_last), .busy(busy)
   );

   weight_bank #(.S(10)) dut10 (
      .clk(clk), .rst(rst),
      .load_valid(load_valid10), .load_ready(load_ready10), .load_data(load_data10),
      .load_done(load_done10), .rd_start(rd_start10), .rd_mode(rd_mode10),
      .rd_addr(rd_addr10), .rd_err(rd_err10), .W(W10), .W_valid(W_valid10),
      .W_ready(W_ready10), .W_last(W_last10), .busy(busy10)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [255:0] row_of(input int base);
      logic [255:0] v;
      for (int c = 0; c < 8; c++) v[c*32 +: 32] = 32'(base + c);
      return v;
   endfunction

   task automatic test_reset();
      rst = 1'b1;
      #3;
      n_checks++;
      if ({W_valid, W_last, load_done, rd_err, busy, load_ready} !== 6'b0) begin
         n_fail++;
         $display("FAIL reset_outs: got %b want 000000", {W_valid, W_last, load_done, rd_err, busy, load_ready});
      end
      n_checks++;
      if (W !== 256'h0) begin n_fail++; $display("FAIL reset_W: got %h want 0", W); end
      @(posedge clk); @(posedge clk);
      #2 rst = 1'b0;
      #1;
      n_checks++;
      if (load_ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: got %b want 0", load_ready); end
      tick();
      n_checks++;
      if (load_ready !== 1'b1) begin n_fail++; $display("FAIL ready_after_edge: got %b want 1", load_ready); end
   endtask

   task automatic single_read(input logic [2:0] row, input logic [255:0] exp_w);
      rd_start = 1'b1; rd_mode = 1'b0; rd_addr = row; W_ready = 1'b0;
      tick();
      rd_start = 1'b0;
      n_checks++;
      if (W !== exp_w) begin n_fail++; $display("FAIL single_W row %0d: got %h want %h", row, W, exp_w); end
      n_checks++;
      if ({W_valid, W_last, busy} !== 3'b111) begin
         n_fail++; $display("FAIL single_flags row %0d: got %b want 111", row, {W_valid, W_last, busy});
      end
      W_ready = 1'b1;
      tick();
      W_ready = 1'b0;
      n_checks++;
      if ({W_valid, W_last, busy} !== 3'b000) begin
         n_fail++; $display("FAIL single_end row %0d: got %b want 000", row, {W_valid, W_last, busy});
      end
   endtask

   task automatic test_single_read();
      rd_start = 1'b1; rd_mode = 1'b0; rd_addr = 3'd5; W_ready = 1'b0;
      tick();
      rd_start = 1'b0;
      tick();
      n_checks++;
      if (W !== RST_ROW || W_valid !== 1'b1 || W_last !== 1'b1) begin
         n_fail++; $display("FAIL single_hold: got %h v=%b l=%b want %h v=1 l=1", W, W_valid, W_last, RST_ROW);
      end
      W_ready = 1'b1;
      tick();
      W_ready = 1'b0;
      n_checks++;
      if (W_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL single_done: got v=%b busy=%b want 0 0", W_valid, busy);
      end
      n_checks++;
      if (W !== RST_ROW) begin n_fail++; $display("FAIL W_retain: got %h want %h", W, RST_ROW); end
      single_read(3'd5, RST_ROW);
   endtask

   task automatic load_all(input int base, output int done_cnt);
      done_cnt = 0;
      for (int k = 0; k < 64; k++) begin
         load_valid = 1'b1; load_data = 32'(base + k);
         #1;
         n_checks++;
         if (load_ready !== 1'b1) begin n_fail++; $display("FAIL load_ready word %0d: got %b want 1", k, load_ready); end
         tick();
         if (load_done === 1'b1) begin
            done_cnt++;
            n_checks++;
            if (k != 63) begin n_fail++; $display("FAIL load_done_early: got pulse at word %0d want 63", k); end
         end
      end
      load_valid = 1'b0;
      n_checks++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL load_idle: got busy=%b want 0", busy); end
      tick();
      n_checks++;
      if (load_done !== 1'b0) begin n_fail++; $display("FAIL load_done_width: got %b want 0", load_done); end
   endtask

   task automatic test_load_sweep();
      int dc;
      load_all(0, dc);
      n_checks++;
      if (dc != 1) begin n_fail++; $display("FAIL load_done_count: got %0d want 1", dc); end
      rd_start = 1'b1; rd_mode = 1'b1; rd_addr = 3'd0; W_ready = 1'b1;
      tick();
      rd_start = 1'b0;
      for (int r = 0; r < 8; r++) begin
         n_checks++;
         if (W !== row_of(8*r) || W_valid !== 1'b1 || W_last !== (r == 7)) begin
            n_fail++; $display("FAIL sweep row %0d: got %h v=%b l=%b want %h v=1 l=%0d", r, W, W_valid, W_last, row_of(8*r), (r == 7));
         end
         tick();
      end
      W_ready = 1'b0;
      n_checks++;
      if (W_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL sweep_end: got v=%b busy=%b want 0 0", W_valid, busy);
      end
   endtask

   task automatic test_stall_sweep();
      bit pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
      logic [255:0] cur_w;
      logic cur_l;
      int exp_row = 0;
      int cyc = 0;
      rd_start = 1'b1; rd_mode = 1'b1; W_ready = 1'b0;
      tick();
      rd_start = 1'b0;
      while (exp_row < 8 && cyc < 64) begin
         W_ready = pat[cyc % 4];
         cur_w = W; cur_l = W_last;
         n_checks++;
         if (W !== row_of(8*exp_row) || W_valid !== 1'b1 || W_last !== (exp_row == 7)) begin
            n_fail++; $display("FAIL stall_row %0d: got %h v=%b l=%b want %h v=1 l=%0d", exp_row, W, W_valid, W_last, row_of(8*exp_row), (exp_row == 7));
         end
         tick();
         if (pat[cyc % 4]) begin
            exp_row++;
         end else begin
            n_checks++;
            if (W !== cur_w || W_last !== cur_l || W_valid !== 1'b1) begin
               n_fail++; $display("FAIL stall_hold cyc %0d: got %h v=%b l=%b want %h v=1 l=%b", cyc, W, W_valid, W_last, cur_w, cur_l);
            end
         end
         cyc++;
      end
      W_ready = 1'b0;
      n_checks++;
      if (exp_row != 8) begin n_fail++; $display("FAIL stall_timeout: got %0d rows want 8", exp_row); end
      n_checks++;
      if (W_valid !== 1'b0 || busy !== 1'b0) begin
         n_fail++; $display("FAIL stall_end: got v=%b busy=%b want 0 0", W_valid, busy);
      end
   endtask

   task automatic test_rd_err();
      load_valid = 1'b1; load_data = 32'd100;
      tick();
      load_valid = 1'b0;
      rd_start = 1'b1; rd_mode = 1'b0; rd_addr = 3'd1;
      tick();
      rd_start = 1'b0;
      n_checks++;
      if (rd_err !== 1'b1 || busy !== 1'b1 || W_valid !== 1'b0) begin
         n_fail++; $display("FAIL err_in_load: got err=%b busy=%b v=%b want 1 1 0", rd_err, busy, W_valid);
      end
      tick();
      n_checks++;
      if (rd_err !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL err_pulse_load: got err=%b busy=%b want 0 1", rd_err, busy);
      end

      rd_start10 = 1'b1; rd_mode10 = 1'b0; rd_addr10 = 4'd10;
      tick();
      rd_start10 = 1'b0;
      n_checks++;
      if (rd_err10 !== 1'b1 || busy10 !== 1'b0 || W_valid10 !== 1'b0) begin
         n_fail++; $display("FAIL err_addr10: got err=%b busy=%b v=%b want 1 0 0", rd_err10, busy10, W_valid10);
      end
      tick();
      n_checks++;
      if (rd_err10 !== 1'b0) begin n_fail++; $display("FAIL err_pulse_addr: got %b want 0", rd_err10); end

      rd_start10 = 1'b1; rd_addr10 = 4'd9; W_ready10 = 1'b0;
      tick();
      rd_start10 = 1'b0;
      n_checks++;
      if (rd_err10 !== 1'b0 || W_valid10 !== 1'b1 || W_last10 !== 1'b1 || W10 !== RST_ROW) begin
         n_fail++; $display("FAIL addr9_read: got err=%b v=%b l=%b W=%h want 0 1 1 %h", rd_err10, W_valid10, W_last10, W10, RST_ROW);
      end
      W_ready10 = 1'b1;
      tick();
      W_ready10 = 1'b0;
      n_checks++;
      if (busy10 !== 1'b0 || W_valid10 !== 1'b0) begin
         n_fail++; $display("FAIL addr9_end: got busy=%b v=%b want 0 0", busy10, W_valid10);
      end
   endtask

   task automatic test_reset_mid_load();
      int dc;
      for (int k = 1; k < 20; k++) begin
         load_valid = 1'b1; load_data = 32'(200 + k);
         tick();
      end
      load_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      n_checks++;
      if (busy !== 1'b0 || load_ready !== 1'b0) begin
         n_fail++; $display("FAIL async_rst: got busy=%b ready=%b want 0 0", busy, load_ready);
      end
      tick();
      rst = 1'b0;
      tick();
      rd_start = 1'b1; rd_mode = 1'b1; W_ready = 1'b1;
      tick();
      rd_start = 1'b0;
      for (int r = 0; r < 8; r++) begin
         n_checks++;
         if (W !== RST_ROW || W_valid !== 1'b1) begin
            n_fail++; $display("FAIL rst_mem row %0d: got %h v=%b want %h v=1", r, W, W_valid, RST_ROW);
         end
         tick();
      end
      W_ready = 1'b0;
      load_all(32'h100, dc);
      n_checks++;
      if (dc != 1) begin n_fail++; $display("FAIL reload_done_count: got %0d want 1", dc); end
      single_read(3'd0, row_of(32'h100));
      single_read(3'd7, row_of(32'h100 + 56));
   endtask

   task automatic test_read_wins();
      rd_start = 1'b1; rd_mode = 1'b0; rd_addr = 3'd2; W_ready = 1'b0;
      load_valid = 1'b1; load_data = 32'hDEAD;
      #1;
      n_checks++;
      if (load_ready !== 1'b0) begin n_fail++; $display("FAIL collide_ready: got %b want 0", load_ready); end
      tick();
      rd_start = 1'b0; load_valid = 1'b0;
      n_checks++;
      if (W !== row_of(32'h100 + 16) || W_valid !== 1'b1 || busy !== 1'b1) begin
         n_fail++; $display("FAIL collide_read: got %h v=%b busy=%b want %h v=1 busy=1", W, W_valid, busy, row_of(32'h100 + 16));
      end
      W_ready = 1'b1;
      tick();
      W_ready = 1'b0;
      single_read(3'd0, row_of(32'h100));
   endtask

   initial begin
      load_valid = 1'b0; load_data = '0; rd_start = 1'b0; rd_mode = 1'b0;
      rd_addr = '0; W_ready = 1'b0;
      load_valid10 = 1'b0; load_data10 = '0; rd_start10 = 1'b0; rd_mode10 = 1'b0;
      rd_addr10 = '0; W_ready10 = 1'b0;
      test_reset();
      test_single_read();
      test_load_sweep();
      test_stall_sweep();
      test_rd_err();
      test_reset_mid_load();
      test_read_wins();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
